// File: rtl/stream_argmax.sv
// stream_argmax: framed running maximum / argmax with beat count and wrap flag.
// Define ARGMAX_SECOND_EN to add the runner-up score and margin outputs.
module stream_argmax #(
    parameter int DW = 32,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_max,
    output logic [IW-1:0] out_idx,
    output logic [IW-1:0] out_cnt,
`ifdef ARGMAX_SECOND_EN
    output logic [DW-1:0] out_second,
    output logic [DW-1:0] out_margin,
`endif
    output logic          out_ovf
);
    typedef logic [DW-1:0] dw_t;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, state_n;
    dw_t max_r;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] cnt_r;
    logic ovf_r;
    logic acc;
    assign in_ready  = state != DONE;
    assign out_valid = state == DONE;
    assign acc       = in_valid && in_ready;
    assign out_max   = max_r;
    assign out_idx   = idx_r;
    assign out_cnt   = cnt_r;
    assign out_ovf   = ovf_r;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        state_n = (state == DONE) ? (out_ready ? IDLE : DONE)
                : acc             ? (in_last ? DONE : ACCUM)
                :                   state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            max_r <= '0;
            idx_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (acc && state == IDLE) begin
            max_r <= in_data;
            idx_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (acc) begin
            // the counter wraps past 2^IW-1; the flag stays set for the frame
            cnt_r <= cnt_r + 1'b1;
            ovf_r <= ovf_r | (&cnt_r);
            if (in_data > max_r) begin
                max_r <= in_data;
                idx_r <= cnt_r + 1'b1;
            end
        end
    end
`ifdef ARGMAX_SECOND_EN
    dw_t second_r;
    assign out_second = second_r;
    assign out_margin = max_r - second_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            second_r <= '0;
        end else if (acc && state == IDLE) begin
            second_r <= '0;
        end else if (acc) begin
            // a repeat of the max counts as the runner-up
            if (in_data > max_r)
                second_r <= max_r;
            else if (in_data > second_r || in_data == max_r)
                second_r <= in_data;
        end
    end
`endif
endmodule

// File: tb/tb_stream_argmax.sv
// tb_stream_argmax: directed and random frames against a queue-based reference,
// run on a default instance and on a narrow IW=2 instance fed the same stream.
module tb_stream_argmax;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic a_in_ready, a_out_valid, a_out_ovf;
    logic b_in_ready, b_out_valid, b_out_ovf;
    logic [DW-1:0] a_out_max, b_out_max;
    logic [7:0] a_out_idx, a_out_cnt;
    logic [1:0] b_out_idx, b_out_cnt;
`ifdef ARGMAX_SECOND_EN
    logic [DW-1:0] a_out_second, a_out_margin, b_out_second, b_out_margin;
`endif
    int total = 0;
    int passed = 0;
    logic [DW-1:0] frame[$];
    logic [DW-1:0] em, es;
    int en, eix;

    always #5 clk = ~clk;

    stream_argmax #(.DW(DW), .IW(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_max(a_out_max), .out_idx(a_out_idx),
        .out_cnt(a_out_cnt),
`ifdef ARGMAX_SECOND_EN
        .out_second(a_out_second), .out_margin(a_out_margin),
`endif
        .out_ovf(a_out_ovf)
    );

    stream_argmax #(.DW(DW), .IW(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_max(b_out_max), .out_idx(b_out_idx),
        .out_cnt(b_out_cnt),
`ifdef ARGMAX_SECOND_EN
        .out_second(b_out_second), .out_margin(b_out_margin),
`endif
        .out_ovf(b_out_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: largest score, its first position, and the best of the rest.
    task automatic model;
        en = frame.size();
        em = '0;
        eix = 0;
        es = '0;
        foreach (frame[i]) if (frame[i] > em) em = frame[i];
        for (int i = en - 1; i >= 0; i--) if (frame[i] == em) eix = i;
        foreach (frame[i]) if (i != eix && frame[i] > es) es = frame[i];
    endtask

    task automatic check_out(input string t);
        chk({t, " valid"}, a_out_valid, 1);
        chk({t, " in_ready"}, a_in_ready, 0);
        chk({t, " max"}, a_out_max, em);
        chk({t, " idx"}, a_out_idx, eix % 256);
        chk({t, " cnt"}, a_out_cnt, (en - 1) % 256);
        chk({t, " ovf"}, a_out_ovf, en > 256);
        chk({t, " b valid"}, b_out_valid, 1);
        chk({t, " b max"}, b_out_max, em);
        chk({t, " b idx"}, b_out_idx, eix % 4);
        chk({t, " b cnt"}, b_out_cnt, (en - 1) % 4);
        chk({t, " b ovf"}, b_out_ovf, en > 4);
`ifdef ARGMAX_SECOND_EN
        chk({t, " second"}, a_out_second, es);
        chk({t, " margin"}, a_out_margin, em - es);
`endif
    endtask

    task automatic run_frame(input string t, input int gapmax, input int hold);
        model();
        for (int i = 0; i < en; i++) begin
            repeat ($urandom_range(0, gapmax)) begin
                in_valid = 1'b0;
                in_data = $urandom;
                in_last = 1'($urandom);
                out_ready = 1'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_data = frame[i];
            in_last = (i == en - 1);
            out_ready = 1'($urandom);
            if (i == 0) chk({t, " ready first"}, a_in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = $urandom;
        out_ready = 1'b0;
        check_out(t);
        for (int k = 0; k < hold; k++) begin
            step();
            chk({t, " hold valid"}, a_out_valid, 1);
            chk({t, " hold in_ready"}, a_in_ready, 0);
            chk({t, " hold max"}, a_out_max, em);
            chk({t, " hold idx"}, a_out_idx, eix % 256);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({t, " drop valid"}, a_out_valid, 0);
        chk({t, " ready after"}, a_in_ready, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("rst valid", a_out_valid, 0);
        chk("rst in_ready", a_in_ready, 1);
        chk("rst max", a_out_max, 0);
        chk("rst idx", a_out_idx, 0);
        chk("rst cnt", a_out_cnt, 0);
        chk("rst ovf", a_out_ovf, 0);

        frame = '{32'd5, 32'd9, 32'd3, 32'd9};
        run_frame("tie", 0, 0);
        frame = '{32'hFFFF_FFFF};
        run_frame("single", 0, 0);
        frame = '{32'd1, 32'd2, 32'd7, 32'd4};
        run_frame("gaps", 3, 5);
        frame = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd6};
        run_frame("wrap", 0, 0);
        frame = '{32'd3};
        run_frame("after wrap", 0, 0);
        frame = '{32'd4, 32'd10, 32'd10, 32'd6};
        run_frame("second", 1, 1);

        in_valid = 1'b1;
        in_data = 32'd100;
        step();
        in_data = 32'd200;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort valid", a_out_valid, 0);
        chk("abort in_ready", a_in_ready, 1);
        chk("abort max", a_out_max, 0);
        chk("abort cnt", a_out_cnt, 0);
        frame = '{32'd8, 32'd2};
        run_frame("post abort", 0, 0);

        frame = '{32'd1, 32'd2, 32'd3};
        in_valid = 1'b1;
        foreach (frame[i]) begin
            in_data = frame[i];
            in_last = (i == 2);
            step();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort done valid", a_out_valid, 0);
        chk("abort done in_ready", a_in_ready, 1);

        frame = {};
        for (int i = 0; i < 257; i++) frame.push_back(32'($urandom_range(0, 50)));
        run_frame("long", 0, 0);

        for (int f = 0; f < 30; f++) begin
            frame = {};
            for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
                case ($urandom_range(0, 2))
                    0: frame.push_back(32'($urandom_range(0, 7)));
                    1: frame.push_back($urandom);
                    default: frame.push_back(32'hFFFF_FFFF - 32'($urandom_range(0, 1)));
                endcase
            end
            run_frame($sformatf("rand%0d", f), 2, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
